// File: rtl/block_move_pkg.sv
// Shared types, colours and helpers for the bouncing-square pattern generator.
//   COORD_W / POS_W : pixel coordinate width and signed candidate width
//   blk_pos_t       : top-left corner of one square
//   axis_t          : result of stepping one axis of one square
//   palette()       : colour of square i
//   axis_step()     : bounce/wrap arithmetic for a single axis
package block_move_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned POS_W   = 12;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned DIV_W   = 8;

  localparam logic [COLOR_W-1:0] BG_COLOR     = 24'hFFFFFF;
  localparam logic [COLOR_W-1:0] BORDER_COLOR = 24'h0000FF;

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

  // Direction bit: positive means right (x) or down (y).
  localparam logic DIR_NEG = 1'b0;
  localparam logic DIR_POS = 1'b1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } blk_pos_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
    logic               hit;
  } axis_t;

  function automatic logic [COLOR_W-1:0] palette(input logic [2:0] idx);
    logic [COLOR_W-1:0] c;
    case (idx)
      3'd0:    c = 24'hFF0000;  // red
      3'd1:    c = 24'h00FF00;  // green
      3'd2:    c = 24'hFFFF00;  // yellow
      3'd3:    c = 24'hFF00FF;  // magenta
      3'd4:    c = 24'h00FFFF;  // cyan
      3'd5:    c = 24'hFFA500;  // orange
      3'd6:    c = 24'h000000;  // black
      default: c = 24'h808080;  // grey
    endcase
    return c;
  endfunction

  // One axis step: candidate is formed signed so a step below zero compares correctly.
  function automatic axis_t axis_step(input logic [COORD_W-1:0] pos,
                                      input logic               dir,
                                      input logic [POS_W-1:0]   s,
                                      input logic [POS_W-1:0]   lo,
                                      input logic [POS_W-1:0]   hi,
                                      input logic               mode);
    axis_t               r;
    logic signed [POS_W-1:0] cand;
    cand  = dir ? ($signed({1'b0, pos}) + $signed(s))
                : ($signed({1'b0, pos}) - $signed(s));
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (cand > $signed(hi)) begin
      r.hit = 1'b1;
      if (mode == MODE_WRAP) begin
        r.pos = COORD_W'(lo);
      end else begin
        r.pos = COORD_W'(hi);
        r.dir = DIR_NEG;
      end
    end else if (cand < $signed(lo)) begin
      r.hit = 1'b1;
      if (mode == MODE_WRAP) begin
        r.pos = COORD_W'(hi);
      end else begin
        r.pos = COORD_W'(lo);
        r.dir = DIR_POS;
      end
    end else begin
      r.pos = COORD_W'(cand);
    end
    return r;
  endfunction

endpackage

// File: rtl/block_mover.sv
// Position and direction state of one square.
//   clk_i, rst_i : pixel clock, synchronous active-high reset
//   update_i     : apply one movement step this cycle (already gated by pause)
//   mode_i       : MODE_BOUNCE / MODE_WRAP
//   pos_o        : registered top-left corner
//   hit_c_o      : combinational, this update reflected or wrapped an axis
module block_mover
  import block_move_pkg::*;
#(
  parameter int unsigned IDX     = 0,
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned V_DISP  = 720,
  parameter int unsigned BORDER  = 20,
  parameter int unsigned BLOCK_W = 40,
  parameter int unsigned STEP    = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     update_i,
  input  logic     mode_i,
  output blk_pos_t pos_o,
  output logic     hit_c_o
);

  localparam logic [POS_W-1:0]   STEP_S = POS_W'(STEP + IDX);
  localparam logic [POS_W-1:0]   XL     = POS_W'(BORDER);
  localparam logic [POS_W-1:0]   XR     = POS_W'(H_DISP - BORDER - BLOCK_W);
  localparam logic [POS_W-1:0]   YT     = POS_W'(BORDER);
  localparam logic [POS_W-1:0]   YB     = POS_W'(V_DISP - BORDER - BLOCK_W);
  localparam logic [COORD_W-1:0] X_RST  = COORD_W'(BORDER + 2 * IDX * BLOCK_W);
  localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(BORDER + IDX * BLOCK_W);
  // Even squares start moving right, odd ones left; all start moving down.
  localparam logic               DX_RST = (IDX % 2 == 0) ? DIR_POS : DIR_NEG;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  axis_t              ax_c, ay_c;

  // Next-state: both axes are stepped independently, so corner hits fix both at once.
  always_comb begin
    ax_c    = axis_step(x_q, dx_q, STEP_S, XL, XR, mode_i);
    ay_c    = axis_step(y_q, dy_q, STEP_S, YT, YB, mode_i);
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_c_o = 1'b0;
    if (update_i) begin
      x_d     = ax_c.pos;
      y_d     = ay_c.pos;
      dx_d    = ax_c.dir;
      dy_d    = ay_c.dir;
      hit_c_o = ax_c.hit | ay_c.hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q  <= X_RST;
      y_q  <= Y_RST;
      dx_q <= DX_RST;
      dy_q <= DIR_POS;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign pos_o.x = x_q;
  assign pos_o.y = y_q;

endmodule

// File: rtl/block_move_multi.sv
// Multi-square bouncing pattern generator for the pixel clock domain.
//   pixel_clk, sys_rst       : clock, synchronous active-high reset
//   mode, pause              : bounce/wrap select and freeze, sampled at update
//   pixel_xpos, pixel_ypos   : coordinate being rendered
//   pixel_data               : RGB888 for the coordinate of the previous cycle
//   edge_hit                 : one-cycle pulse after an update that hit an edge
module block_move_multi
  import block_move_pkg::*;
#(
  parameter int unsigned H_DISP    = 1280,
  parameter int unsigned V_DISP    = 720,
  parameter int unsigned BORDER    = 20,
  parameter int unsigned BLOCK_W   = 40,
  parameter int unsigned N_BLK     = 4,
  parameter int unsigned STEP      = 1,
  parameter int unsigned SPEED_DIV = 1
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  input  logic               mode,
  input  logic               pause,
  input  logic [COORD_W-1:0] pixel_xpos,
  input  logic [COORD_W-1:0] pixel_ypos,
  output logic [COLOR_W-1:0] pixel_data,
  output logic               edge_hit
);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SPEED_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_DISP - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_DISP - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [COLOR_W-1:0] pixel_data_q, pixel_data_d;
  logic               edge_hit_q, edge_hit_d;
  logic               tick_c, update_c;
  logic [N_BLK-1:0]   hit_c, cover_c;
  blk_pos_t           pos_w [N_BLK];
  logic               out_c, border_c;

  // Frame divider: the tick is the last active pixel, so moves never tear a frame.
  always_comb begin
    tick_c   = (pixel_xpos == X_LAST) && (pixel_ypos == Y_LAST);
    update_c = tick_c && (div_q == DIV_LAST);
    div_d    = div_q;
    if (update_c) begin
      div_d = '0;
    end else if (tick_c) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < N_BLK; g++) begin : gen_blk
    block_mover #(
      .IDX     (g),
      .H_DISP  (H_DISP),
      .V_DISP  (V_DISP),
      .BORDER  (BORDER),
      .BLOCK_W (BLOCK_W),
      .STEP    (STEP)
    ) u_mover (
      .clk_i    (pixel_clk),
      .rst_i    (sys_rst),
      .update_i (update_c & ~pause),
      .mode_i   (mode),
      .pos_o    (pos_w[g]),
      .hit_c_o  (hit_c[g])
    );

    // Square coverage in 12 bits so x+BLOCK_W cannot overflow.
    assign cover_c[g] =
      ({1'b0, pixel_xpos} >= {1'b0, pos_w[g].x}) &&
      ({1'b0, pixel_xpos} <  ({1'b0, pos_w[g].x} + POS_W'(BLOCK_W))) &&
      ({1'b0, pixel_ypos} >= {1'b0, pos_w[g].y}) &&
      ({1'b0, pixel_ypos} <  ({1'b0, pos_w[g].y} + POS_W'(BLOCK_W)));
  end

  // Colour priority: blanking, border, lowest-index square, background.
  always_comb begin
    out_c    = (pixel_xpos >= COORD_W'(H_DISP)) || (pixel_ypos >= COORD_W'(V_DISP));
    border_c = (pixel_xpos <  COORD_W'(BORDER)) ||
               (pixel_xpos >= COORD_W'(H_DISP - BORDER)) ||
               (pixel_ypos <  COORD_W'(BORDER)) ||
               (pixel_ypos >= COORD_W'(V_DISP - BORDER));
    pixel_data_d = BG_COLOR;
    if (!out_c) begin
      if (border_c) begin
        pixel_data_d = BORDER_COLOR;
      end else begin
        // Descending scan so the lowest covering index is assigned last.
        for (int i = int'(N_BLK) - 1; i >= 0; i--) begin
          if (cover_c[i]) begin
            pixel_data_d = palette(3'(i));
          end
        end
      end
    end
    edge_hit_d = |hit_c;
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      div_q        <= '0;
      pixel_data_q <= '0;
      edge_hit_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      pixel_data_q <= pixel_data_d;
      edge_hit_q   <= edge_hit_d;
    end
  end

  assign pixel_data = pixel_data_q;
  assign edge_hit   = edge_hit_q;

endmodule

// File: tb/tb_block_move_multi.sv
// Directed self-checking bench for block_move_multi.
// dut  : default 1280x720 geometry, 4 squares, SPEED_DIV=1.
// dut3 : small 400x140 geometry, 2 squares, STEP=0, SPEED_DIV=3.
module tb_block_move_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        pause;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [23:0] pd;
  logic [23:0] pd3;
  logic        hit;
  logic        hit3;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] BLUE_B = 24'h0000FF;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  always #5 clk = ~clk;

  block_move_multi dut (
    .pixel_clk  (clk),
    .sys_rst    (rst),
    .mode       (mode),
    .pause      (pause),
    .pixel_xpos (xpos),
    .pixel_ypos (ypos),
    .pixel_data (pd),
    .edge_hit   (hit)
  );

  block_move_multi #(
    .H_DISP    (400),
    .V_DISP    (140),
    .BORDER    (20),
    .BLOCK_W   (40),
    .N_BLK     (2),
    .STEP      (0),
    .SPEED_DIV (3)
  ) dut3 (
    .pixel_clk  (clk),
    .sys_rst    (rst),
    .mode       (mode),
    .pause      (pause),
    .pixel_xpos (xpos),
    .pixel_ypos (ypos),
    .pixel_data (pd3),
    .edge_hit   (hit3)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame ticks on the large instance; coordinate parked at (0,0) afterwards.
  task automatic tick_main(input int n);
    xpos = 11'd1279; ypos = 11'd719;
    cyc(n);
    xpos = 11'd0; ypos = 11'd0;
  endtask

  task automatic tick_small(input int n);
    xpos = 11'd399; ypos = 11'd139;
    cyc(n);
    xpos = 11'd0; ypos = 11'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    xpos = 11'd0; ypos = 11'd0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b0; pause = 1'b0;
    rst = 1'b1; xpos = 11'd0; ypos = 11'd0;
    cyc(2);
    checks++; if (pd !== 24'h0) begin errors++; $display("FAIL rst_pd got %h exp %h", pd, 24'h0); end
    checks++; if (pd3 !== 24'h0) begin errors++; $display("FAIL rst_pd3 got %h exp %h", pd3, 24'h0); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", hit); end
    rst = 1'b0;
    xpos = 11'd0; ypos = 11'd0; cyc(1);
    checks++; if (pd !== BLUE_B) begin errors++; $display("FAIL px_0_0 got %h exp %h", pd, BLUE_B); end
    xpos = 11'd20; ypos = 11'd20; cyc(1);
    checks++; if (pd !== RED) begin errors++; $display("FAIL px_20_20 got %h exp %h", pd, RED); end
    xpos = 11'd60; ypos = 11'd60; cyc(1);
    checks++; if (pd !== WHITE) begin errors++; $display("FAIL px_60_60 got %h exp %h", pd, WHITE); end
    xpos = 11'd100; ypos = 11'd60; cyc(1);
    checks++; if (pd !== GREEN) begin errors++; $display("FAIL px_100_60 got %h exp %h", pd, GREEN); end
    xpos = 11'd139; ypos = 11'd99; cyc(1);
    checks++; if (pd !== GREEN) begin errors++; $display("FAIL px_139_99 got %h exp %h", pd, GREEN); end
    xpos = 11'd140; ypos = 11'd99; cyc(1);
    checks++; if (pd !== WHITE) begin errors++; $display("FAIL px_140_99 got %h exp %h", pd, WHITE); end
    xpos = 11'd1300; ypos = 11'd10; cyc(1);
    checks++; if (pd !== WHITE) begin errors++; $display("FAIL px_blank got %h exp %h", pd, WHITE); end
    xpos = 11'd1260; ypos = 11'd300; cyc(1);
    checks++; if (pd !== BLUE_B) begin errors++; $display("FAIL px_rborder got %h exp %h", pd, BLUE_B); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit2 got %b exp 0", hit); end
  endtask

  // Block 1 (step 2) walks left from 100; reaches XL=20 after 40 updates, wraps on the 41st.
  task automatic test_wrap();
    do_reset();
    mode = 1'b1;
    tick_main(40);
    checks++; if (dut.gen_blk[1].u_mover.x_q !== 11'd20) begin errors++; $display("FAIL wrap_x40 got %0d exp 20", dut.gen_blk[1].u_mover.x_q); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wrap_hit40 got %b exp 0", hit); end
    tick_main(1);
    checks++; if (dut.gen_blk[1].u_mover.x_q !== 11'd1220) begin errors++; $display("FAIL wrap_x41 got %0d exp 1220", dut.gen_blk[1].u_mover.x_q); end
    checks++; if (dut.gen_blk[1].u_mover.dx_q !== 1'b0) begin errors++; $display("FAIL wrap_dx got %b exp 0", dut.gen_blk[1].u_mover.dx_q); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wrap_hit41 got %b exp 1", hit); end
    cyc(1);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wrap_hit_pulse got %b exp 0", hit); end
    // Block 1 is now at (1220, 60+2*41=142).
    xpos = 11'd1220; ypos = 11'd142; cyc(1);
    checks++; if (pd !== GREEN) begin errors++; $display("FAIL wrap_px_in got %h exp %h", pd, GREEN); end
    xpos = 11'd1219; ypos = 11'd142; cyc(1);
    checks++; if (pd !== WHITE) begin errors++; $display("FAIL wrap_px_out got %h exp %h", pd, WHITE); end
  endtask

  // Block 0 goes right one pixel per update: 1219 after 1199, 1220 after 1200, reflects on 1201.
  task automatic test_bounce();
    do_reset();
    mode = 1'b0;
    tick_main(1199);
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd1219) begin errors++; $display("FAIL bnc_x1199 got %0d exp 1219", dut.gen_blk[0].u_mover.x_q); end
    tick_main(1);
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd1220) begin errors++; $display("FAIL bnc_x1200 got %0d exp 1220", dut.gen_blk[0].u_mover.x_q); end
    checks++; if (dut.gen_blk[0].u_mover.dx_q !== 1'b1) begin errors++; $display("FAIL bnc_dx1200 got %b exp 1", dut.gen_blk[0].u_mover.dx_q); end
    tick_main(1);
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd1220) begin errors++; $display("FAIL bnc_x1201 got %0d exp 1220", dut.gen_blk[0].u_mover.x_q); end
    checks++; if (dut.gen_blk[0].u_mover.dx_q !== 1'b0) begin errors++; $display("FAIL bnc_dx1201 got %b exp 0", dut.gen_blk[0].u_mover.dx_q); end
    // y: reaches 660 at update 640, reflects at 641, then falls to 100 by 1201.
    checks++; if (dut.gen_blk[0].u_mover.y_q !== 11'd100) begin errors++; $display("FAIL bnc_y1201 got %0d exp 100", dut.gen_blk[0].u_mover.y_q); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL bnc_hit got %b exp 1", hit); end
    cyc(1);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL bnc_hit_pulse got %b exp 0", hit); end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    xpos = 11'd1279; ypos = 11'd719;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL pause_hit%0d got %b exp 0", k, hit); end
    end
    xpos = 11'd0; ypos = 11'd0;
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd1220) begin errors++; $display("FAIL pause_x got %0d exp 1220", dut.gen_blk[0].u_mover.x_q); end
    checks++; if (dut.gen_blk[0].u_mover.y_q !== 11'd100) begin errors++; $display("FAIL pause_y got %0d exp 100", dut.gen_blk[0].u_mover.y_q); end
    pause = 1'b0;
    tick_main(1);
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd1219) begin errors++; $display("FAIL unpause_x got %0d exp 1219", dut.gen_blk[0].u_mover.x_q); end
  endtask

  // dut3 block 1 (step 1) moves left from x=100 only on every third tick.
  task automatic test_speed_div();
    do_reset();
    mode = 1'b0; pause = 1'b0;
    tick_small(1);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd100) begin errors++; $display("FAIL div_t1 got %0d exp 100", dut3.gen_blk[1].u_mover.x_q); end
    tick_small(1);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd100) begin errors++; $display("FAIL div_t2 got %0d exp 100", dut3.gen_blk[1].u_mover.x_q); end
    tick_small(1);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd99) begin errors++; $display("FAIL div_t3 got %0d exp 99", dut3.gen_blk[1].u_mover.x_q); end
    checks++; if (dut3.gen_blk[1].u_mover.y_q !== 11'd61) begin errors++; $display("FAIL div_t3y got %0d exp 61", dut3.gen_blk[1].u_mover.y_q); end
    tick_small(3);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd98) begin errors++; $display("FAIL div_t6 got %0d exp 98", dut3.gen_blk[1].u_mover.x_q); end
    // Ticks 7..9 paused (update at 9 suppressed), divider keeps counting.
    pause = 1'b1;
    tick_small(3);
    pause = 1'b0;
    tick_small(2);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd98) begin errors++; $display("FAIL div_t11 got %0d exp 98", dut3.gen_blk[1].u_mover.x_q); end
    tick_small(1);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd97) begin errors++; $display("FAIL div_t12 got %0d exp 97", dut3.gen_blk[1].u_mover.x_q); end
  endtask

  // Wrap mode, 41 updates: block 1 reaches (59,40) on top of stationary block 0 at (20,20).
  task automatic test_overlap();
    do_reset();
    mode = 1'b1; pause = 1'b0;
    tick_small(123);
    checks++; if (dut3.gen_blk[1].u_mover.x_q !== 11'd59) begin errors++; $display("FAIL ovl_x got %0d exp 59", dut3.gen_blk[1].u_mover.x_q); end
    checks++; if (dut3.gen_blk[1].u_mover.y_q !== 11'd40) begin errors++; $display("FAIL ovl_y got %0d exp 40", dut3.gen_blk[1].u_mover.y_q); end
    xpos = 11'd59; ypos = 11'd40; cyc(1);
    checks++; if (pd3 !== RED) begin errors++; $display("FAIL ovl_px_both got %h exp %h", pd3, RED); end
    xpos = 11'd60; ypos = 11'd40; cyc(1);
    checks++; if (pd3 !== GREEN) begin errors++; $display("FAIL ovl_px_b1 got %h exp %h", pd3, GREEN); end
    xpos = 11'd40; ypos = 11'd30; cyc(1);
    checks++; if (pd3 !== RED) begin errors++; $display("FAIL ovl_px_b0 got %h exp %h", pd3, RED); end
    mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    tick_main(3);
    xpos = 11'd500; ypos = 11'd300;
    rst = 1'b1;
    cyc(1);
    checks++; if (pd !== 24'h0) begin errors++; $display("FAIL mrst_pd got %h exp 0", pd); end
    checks++; if (dut.gen_blk[0].u_mover.x_q !== 11'd20 || dut.gen_blk[0].u_mover.y_q !== 11'd20) begin errors++; $display("FAIL mrst_b0 got %0d,%0d exp 20,20", dut.gen_blk[0].u_mover.x_q, dut.gen_blk[0].u_mover.y_q); end
    checks++; if (dut.gen_blk[0].u_mover.dx_q !== 1'b1) begin errors++; $display("FAIL mrst_b0dx got %b exp 1", dut.gen_blk[0].u_mover.dx_q); end
    checks++; if (dut.gen_blk[3].u_mover.x_q !== 11'd260 || dut.gen_blk[3].u_mover.y_q !== 11'd140) begin errors++; $display("FAIL mrst_b3 got %0d,%0d exp 260,140", dut.gen_blk[3].u_mover.x_q, dut.gen_blk[3].u_mover.y_q); end
    checks++; if (dut.gen_blk[3].u_mover.dx_q !== 1'b0 || dut.gen_blk[3].u_mover.dy_q !== 1'b1) begin errors++; $display("FAIL mrst_b3dir got %b%b exp 01", dut.gen_blk[3].u_mover.dx_q, dut.gen_blk[3].u_mover.dy_q); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mrst_hit got %b exp 0", hit); end
    rst = 1'b0;
    xpos = 11'd20; ypos = 11'd20; cyc(1);
    checks++; if (pd !== RED) begin errors++; $display("FAIL mrst_px got %h exp %h", pd, RED); end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; pause = 1'b0;
    xpos = 11'd0; ypos = 11'd0;
    #1;
    test_reset();
    test_wrap();
    test_bounce();
    test_pause();
    test_speed_div();
    test_overlap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_move_multi.md
# block_move_multi

Multi-block bouncing-square pattern generator: the parametrised successor of the single-block moving-square display. Draws a border, a background and `N_BLK` independently moving coloured squares. Each square bounces off, or wraps around, the inner border edges and advances once every `SPEED_DIV` frames. It sits between `video_driver` (which supplies `pixel_xpos`/`pixel_ypos`) and `dvi_transmitter_top` (which consumes `pixel_data` via the driver) in the pixel clock domain.

## Interface
- `H_DISP`, 1280: active pixels per line.
- `V_DISP`, 720: active lines per frame.
- `BORDER`, 20: border thickness in pixels.
- `BLOCK_W`, 40: square side in pixels.
- `N_BLK`, 4: number of squares, 1..8.
- `STEP`, 1: base step in pixels per update; block i steps `STEP+i` in both x and y.
- `SPEED_DIV`, 1: frames per position update, 1..255.
- `pixel_clk` in 1: pixel clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `mode` in 1: 0 = bounce, 1 = wrap. Sampled only at update.
- `pause` in 1: 1 = freeze all positions. Sampled only at update.
- `pixel_xpos` in 11: current x coordinate, valid 0..H_DISP-1.
- `pixel_ypos` in 11: current y coordinate, valid 0..V_DISP-1.
- `pixel_data` out 24: RGB888 for the coordinate presented one cycle earlier.
- `edge_hit` out 1: one-cycle pulse on an update in which at least one block reflected or wrapped.

## Operation
- Legal parameter sets satisfy `N_BLK*2*BLOCK_W <= H_DISP-2*BORDER` and `N_BLK*BLOCK_W <= V_DISP-2*BORDER`.
- Inner area bounds: `XL=BORDER`, `XR=H_DISP-BORDER-BLOCK_W`, `YT=BORDER`, `YB=V_DISP-BORDER-BLOCK_W`. These are the limits for a block's top-left corner.
- Reset values:
  - Block i: `x=BORDER+2*i*BLOCK_W`, `y=BORDER+i*BLOCK_W`.
  - Block i direction: `dx` = right when i is even, left when i is odd; `dy` = down.
  - Frame divider = 0; `pixel_data` = 0; `edge_hit` = 0.
- Frame tick: the cycle in which `pixel_xpos==H_DISP-1 && pixel_ypos==V_DISP-1`.
  - On each tick the divider increments.
  - When it reaches `SPEED_DIV-1` it returns to 0 and an update fires. With `SPEED_DIV=1`, every tick is an update.
- Update with `pause=1`: positions and directions are held, no `edge_hit`, and the divider keeps running.
- Update in bounce mode, x axis (y axis is identical using YT/YB), with s=`STEP+i`:
  - Candidate `nx = x ± s`, computed 12-bit signed.
  - If `nx > XR`: `x=XR`, dx becomes left, hit.
  - If `nx < XL`: `x=XL`, dx becomes right, hit.
  - Otherwise `x=nx`.
- Update in wrap mode: direction never changes.
  - If `nx > XR`: `x=XL`, hit.
  - If `nx < XL`: `x=XR`, hit.
- Both axes of a block hitting in the same update (corner) is legal. Both axes are corrected in the same update.
- Pixel colour is chosen in this priority order:
  1. Border (`xpos<BORDER`, `xpos>=H_DISP-BORDER`, `ypos<BORDER` or `ypos>=V_DISP-BORDER`): `BORDER_COLOR`.
  2. Lowest-index block whose square covers the pixel (`x<=xpos<x+BLOCK_W`, same for y): `palette(i)`.
  3. Otherwise: `BG_COLOR`.
- Position registers update only at the tick, i.e. after the last active pixel. The rendered frame is therefore never torn.
- Out-of-range coordinates (blanking) render `BG_COLOR`.

## Timing
- `pixel_data` is registered with 1-cycle latency from `pixel_xpos`/`pixel_ypos`.
- New positions are visible from the first pixel (0,0) of the next frame.
- `edge_hit` asserts in the cycle after the tick that produced the update, for exactly 1 cycle.
- Reset asserted mid-frame: all state returns to its reset values on the next edge, and `pixel_data` is 0 from the cycle after reset is sampled.

## Structure
- Package `block_move_pkg`:
  - `BG_COLOR` = 24'hFFFFFF.
  - `BORDER_COLOR` = 24'h0000FF.
  - 8-entry palette function `palette(i)`: red, green, yellow, magenta, cyan, orange, black, grey.
  - `MODE_BOUNCE`/`MODE_WRAP` constants.
- Sub-module `block_mover`: per-block x/y/direction registers and the step/bound arithmetic. Parameterised by index, instantiated `N_BLK` times via generate.
- The top level holds the frame divider, the priority colour mux and the `edge_hit` register.

## Test plan
- Reset, 1280x720, `N_BLK=4`, `STEP=1` -> `pixel_data` at (0,0) = `BORDER_COLOR`; at (20,20) = red; at (60,60) = `BG_COLOR`; `edge_hit=0`.
- Bounce: block 0 at x=XR-1 moving right, `STEP=1`, block 0's y/dy not at a bound -> after one update `x=XR` (1220), dx still right, no hit. After the next update `x=XR`, dx left, `edge_hit` pulses once.
- Wrap: `mode=1`, block 1 (s=2) at x=XL+1 moving left -> after update `x=XR`, dx unchanged, `edge_hit`=1 for 1 cycle.
- `SPEED_DIV=3` -> positions change only on every third frame tick. `pause=1` over 5 ticks -> positions unchanged, no `edge_hit`.
- Overlap: blocks 0 and 1 forced to the same x,y -> the covered pixel shows red (block 0 wins).
- Assert `sys_rst` at mid-frame coordinate (500,300) -> next cycle all positions equal their reset values and `pixel_data=0`.
